zbus_strobe_filter: RTL
=======================

Name: zbus_strobe_filter

Overview:
- Clocked front-end filter for the raw Z80 bus strobes (ziorq_n, zmreq_n, zrd_n, zwr_n).
- Sits directly upstream of the CPLD access decoder, which drives the W5300/SL811 chip selects, brd_n/bwr_n and the register ports #83AB/#82AB/#81AB/#80AB/#7FAB.
- Synchronises each strobe to fclk and rejects pulses shorter than FILT_LEN samples.
- Emits clean filtered strobes plus one-cycle begin/end pulses for IO and memory read/write cycles, and counts rejected glitches.

Parameters:
- SYNC_STAGES, 2: synchroniser flops per strobe, minimum 2.
- FILT_LEN, 3: consecutive equal synchronised samples needed to change a filtered strobe, range 1..15.

Ports:
- fclk  in  1  filter clock, 42 ns period.
- rst  in  1  synchronous active-high reset.
- ziorq_n  in  1  raw Z80 IORQ, asynchronous.
- zmreq_n  in  1  raw Z80 MREQ, asynchronous.
- zrd_n  in  1  raw Z80 RD, asynchronous.
- zwr_n  in  1  raw Z80 WR, asynchronous.
- f_iorq_n  out  1  filtered IORQ.
- f_mreq_n  out  1  filtered MREQ.
- f_rd_n  out  1  filtered RD.
- f_wr_n  out  1  filtered WR.
- io_rd_beg  out  1  one-cycle pulse, IO read cycle started.
- io_wr_beg  out  1  one-cycle pulse, IO write cycle started.
- mem_rd_beg  out  1  one-cycle pulse, memory read cycle started.
- mem_wr_beg  out  1  one-cycle pulse, memory write cycle started.
- io_end  out  1  one-cycle pulse, IO read/write cycle ended.
- mem_end  out  1  one-cycle pulse, memory read/write cycle ended.
- glitch_cnt  out  8  saturating count of rejected strobe glitches.

Behaviour:
- Single clock domain, fclk. Reset is synchronous active-high, sampled on the fclk rising edge.
- Reset values:
  - All sync flops = 1.
  - f_* = 1.
  - Per-strobe counters = 0.
  - All *_beg and *_end = 0.
  - glitch_cnt = 0.
  - Edge-detect history = idle.
- Synchroniser: per strobe, a chain of SYNC_STAGES flops; s_x is the last stage.
- Per-strobe filter, with a counter cnt of width 4:
  - If s_x == f_x: cnt <= 0. If cnt was nonzero, this is a rejected glitch and glitch_cnt increments.
  - If s_x != f_x and cnt == FILT_LEN-1: f_x <= s_x and cnt <= 0.
  - Otherwise (s_x != f_x): cnt <= cnt+1.
- Latency: raw level first sampled at edge E0 and held stable → f_x changes at edge E0+SYNC_STAGES+FILT_LEN-1 (E0+4 for defaults).
- Pulses narrower than FILT_LEN fclk periods after synchronisation never reach f_x.
- Glitch count: glitch_cnt saturates at 255. Several strobes glitching on the same edge add their number, clamped to 255.
- Cycle conditions, computed from filtered strobes:
  - io_rd = !f_iorq_n & !f_rd_n & f_wr_n.
  - io_wr = !f_iorq_n & !f_wr_n & f_rd_n.
  - mem_rd / mem_wr: same, using f_mreq_n.
- Pulse generation:
  - Condition history is registered.
  - *_beg is asserted for exactly one fclk cycle, on the edge after its condition goes 0→1.
  - io_end pulses for one cycle on the edge after (io_rd|io_wr) goes 1→0. mem_end is the same for mem_rd|mem_wr.
- Cases that produce no pulse:
  - IORQ with both RD and WR high (interrupt acknowledge).
  - MREQ with both RD and WR high (refresh).
  - f_rd_n and f_wr_n both low (illegal); any condition already active drops and emits its *_end.
- Simultaneous IORQ and MREQ low (illegal): IO and memory conditions evaluate independently. No arbitration.
- All outputs are registered; no combinational path from z* inputs to outputs.
- Reset mid-cycle:
  - The next edge forces idle state.
  - No *_end pulse is produced for the aborted cycle.
- After reset release with strobes already low: normal filtering applies, and a *_beg may fire E0+SYNC_STAGES+FILT_LEN edges later.
- glitch_cnt is cleared only by rst.

Test Plan:
- Reset with all z* high, hold 5 cycles, release → f_*=1, all pulses 0, glitch_cnt=0.
- ziorq_n=0 and zrd_n=0 together before edge E0, held 20 cycles, then both released → f_iorq_n/f_rd_n fall at E0+4, io_rd_beg high only at E0+5, io_end one cycle 5 edges after release, no mem_* pulses.
- zmreq_n low with zrd_n/zwr_n high for 10 cycles (refresh) → f_mreq_n falls, no mem_rd_beg/mem_wr_beg/mem_end, glitch_cnt=0.
- zwr_n 60 ns pulse (1–2 samples) during idle, repeated 300 times → f_wr_n stays 1, glitch_cnt saturates at 255, never wraps.
- Memory write in progress (mem_wr active), rst pulsed 1 cycle → next edge f_*=1, mem_end never asserts, glitch_cnt=0.
- zrd_n and zwr_n both low with ziorq_n low → no io_rd_beg/io_wr_beg. Then zwr_n released → io_rd_beg fires once, 5 edges after release.

Source files
------------

// File: rtl/zbus_strobe_filter.sv
// Z80 bus strobe front-end: synchronises IORQ/MREQ/RD/WR to fclk, rejects short pulses,
// and derives one-cycle begin/end pulses for IO and memory read/write cycles.
module zbus_strobe_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       ziorq_n,
  input  logic       zmreq_n,
  input  logic       zrd_n,
  input  logic       zwr_n,
  output logic       f_iorq_n,
  output logic       f_mreq_n,
  output logic       f_rd_n,
  output logic       f_wr_n,
  output logic       io_rd_beg,
  output logic       io_wr_beg,
  output logic       mem_rd_beg,
  output logic       mem_wr_beg,
  output logic       io_end,
  output logic       mem_end,
  output logic [7:0] glitch_cnt
);

  localparam logic [3:0] LAST = 4'(FILT_LEN - 1);

  // Strobe bit order throughout: [3]=IORQ, [2]=MREQ, [1]=RD, [0]=WR
  logic [3:0]             raw;
  logic [SYNC_STAGES-1:0] sync_chain [4];
  logic [3:0]             s;
  logic [3:0]             f;
  logic [3:0]             f_next;
  logic [3:0]             cnt      [4];
  logic [3:0]             cnt_next [4];
  logic [3:0]             glitch_hits;
  logic [2:0]             glitch_inc;
  logic [8:0]             glitch_sum;
  logic [7:0]             glitch_next;
  logic [3:0]             cond;
  logic [3:0]             prev_cond;
  logic                   io_any;
  logic                   mem_any;
  logic                   prev_io_any;
  logic                   prev_mem_any;

  assign raw = {ziorq_n, zmreq_n, zrd_n, zwr_n};

  always_ff @(posedge fclk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) sync_chain[k] <= '1;
    end else begin
      for (int k = 0; k < 4; k++)
        sync_chain[k] <= {sync_chain[k][SYNC_STAGES-2:0], raw[k]};
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) s[k] = sync_chain[k][SYNC_STAGES-1];
  end

  // A sample that returns to the filtered level before the run completes is a rejected glitch
  always_comb begin
    f_next      = f;
    glitch_hits = '0;
    for (int k = 0; k < 4; k++) begin
      cnt_next[k] = cnt[k];
      if (s[k] == f[k]) begin
        cnt_next[k]    = '0;
        glitch_hits[k] = (cnt[k] != 4'd0);
      end else if (cnt[k] == LAST) begin
        f_next[k]   = s[k];
        cnt_next[k] = '0;
      end else begin
        cnt_next[k] = cnt[k] + 4'd1;
      end
    end
  end

  always_comb begin
    glitch_inc  = {2'b00, glitch_hits[0]} + {2'b00, glitch_hits[1]}
                + {2'b00, glitch_hits[2]} + {2'b00, glitch_hits[3]};
    glitch_sum  = {1'b0, glitch_cnt} + {6'b0, glitch_inc};
    glitch_next = (glitch_sum > 9'd255) ? 8'hFF : glitch_sum[7:0];
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      f          <= '1;
      glitch_cnt <= '0;
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else begin
      f          <= f_next;
      glitch_cnt <= glitch_next;
      for (int k = 0; k < 4; k++) cnt[k] <= cnt_next[k];
    end
  end

  assign f_iorq_n = f[3];
  assign f_mreq_n = f[2];
  assign f_rd_n   = f[1];
  assign f_wr_n   = f[0];

  always_comb begin
    cond[3]      = ~f[3] & ~f[1] &  f[0];
    cond[2]      = ~f[3] & ~f[0] &  f[1];
    cond[1]      = ~f[2] & ~f[1] &  f[0];
    cond[0]      = ~f[2] & ~f[0] &  f[1];
    io_any       = cond[3] | cond[2];
    mem_any      = cond[1] | cond[0];
    prev_io_any  = prev_cond[3] | prev_cond[2];
    prev_mem_any = prev_cond[1] | prev_cond[0];
  end

  // Clearing the history on reset suppresses any end pulse for an aborted cycle
  always_ff @(posedge fclk) begin
    if (rst) begin
      prev_cond  <= '0;
      io_rd_beg  <= 1'b0;
      io_wr_beg  <= 1'b0;
      mem_rd_beg <= 1'b0;
      mem_wr_beg <= 1'b0;
      io_end     <= 1'b0;
      mem_end    <= 1'b0;
    end else begin
      prev_cond  <= cond;
      io_rd_beg  <= cond[3] & ~prev_cond[3];
      io_wr_beg  <= cond[2] & ~prev_cond[2];
      mem_rd_beg <= cond[1] & ~prev_cond[1];
      mem_wr_beg <= cond[0] & ~prev_cond[0];
      io_end     <= prev_io_any & ~io_any;
      mem_end    <= prev_mem_any & ~mem_any;
    end
  end

endmodule
